ps2_rx: RTL

PS/2 device-to-host receiver for keyboard/mouse ports. Takes raw asynchronous `ps2_clk`/`ps2_data` pins and double-flop synchronizes both. It then glitch-filters the clock, detects falling edges, deserializes 11-bit frames and checks start, parity and stop bits. Good bytes go into a first-word-fall-through FIFO read by the CPU-side I/O register block.

---
 rtl/ps2_rx.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver with clock glitch filter, frame checking and FWFT byte FIFO
module ps2_rx #(
  parameter int FILTER     = 8,
  parameter int TIMEOUT    = 20000,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       res,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ack,
  output logic       frame_error,
  output logic       overflow,
  input  logic       err_clr
);
  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;
  logic [1:0] cs_q, ds_q;
  logic [7:0] fcnt_q, fcnt_d;
  logic fclk_q, fclk_d, fprev_q, fall_q;
  state_t st_q, st_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  logic par_q, par_d, stop_q, stop_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic to_q, to_d;
  logic [7:0] mem_q [2**DEPTH_LOG2];
  logic [DEPTH_LOG2:0] wp_q, wp_d, rp_q, rp_d;
  logic ovf_q, ovf_d;
  logic din, differ, ok, push, pop, full, empty, wr;
  assign din    = ds_q[1];
  assign differ = cs_q[1] != fclk_q;
  always_comb begin
    fcnt_d = differ ? fcnt_q + 8'd1 : 8'd0;
    fclk_d = fclk_q;
    if (differ && fcnt_q == 8'(FILTER - 1)) begin
      fclk_d = cs_q[1];
      fcnt_d = 8'd0;
    end
  end
  always_comb begin
    st_d   = st_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    par_d  = par_q;
    stop_d = stop_q;
    tcnt_d = 16'd0;
    to_d   = 1'b0;
    case (st_q)
      IDLE: if (fall_q && !din) begin
        st_d  = RECV;
        bit_d = 4'd1;
      end
      RECV: if (fall_q) begin
        bit_d = bit_q + 4'd1;
        if (bit_q <= 4'd8) sh_d = {din, sh_q[7:1]};
        if (bit_q == 4'd9) par_d = din;
        if (bit_q == 4'd10) begin
          stop_d = din;
          st_d   = CHECK;
        end
      end else if (tcnt_q == 16'(TIMEOUT - 1)) begin
        st_d = IDLE;
        to_d = 1'b1;
      end else tcnt_d = tcnt_q + 16'd1;
      default: st_d = IDLE;
    endcase
  end
  // Odd parity across data and parity bit, plus a high stop bit
  assign ok          = stop_q & ^{sh_q, par_q};
  assign push        = st_q == CHECK && ok;
  assign frame_error = (st_q == CHECK && !ok) || to_q;
  assign empty = wp_q == rp_q;
  assign full  = wp_q[DEPTH_LOG2] != rp_q[DEPTH_LOG2] && wp_q[DEPTH_LOG2-1:0] == rp_q[DEPTH_LOG2-1:0];
  assign pop   = ack & ~empty;
  assign wr    = push & (~full | pop);
  always_comb begin
    wp_d  = wp_q + (DEPTH_LOG2+1)'(wr);
    rp_d  = rp_q + (DEPTH_LOG2+1)'(pop);
    ovf_d = (push & full & ~pop) | (ovf_q & ~err_clr);
  end
  assign valid    = ~empty;
  assign data     = valid ? mem_q[rp_q[DEPTH_LOG2-1:0]] : 8'h00;
  assign overflow = ovf_q;
  always_ff @(posedge clk) if (wr) mem_q[wp_q[DEPTH_LOG2-1:0]] <= sh_q;
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cs_q    <= 2'b11;
      ds_q    <= 2'b11;
      fcnt_q  <= 8'd0;
      fclk_q  <= 1'b1;
      fprev_q <= 1'b1;
      fall_q  <= 1'b0;
      st_q    <= IDLE;
      bit_q   <= 4'd0;
      sh_q    <= 8'd0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      tcnt_q  <= 16'd0;
      to_q    <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cs_q    <= {cs_q[0], ps2_clk};
      ds_q    <= {ds_q[0], ps2_data};
      fcnt_q  <= fcnt_d;
      fclk_q  <= fclk_d;
      fprev_q <= fclk_q;
      fall_q  <= fprev_q & ~fclk_q;
      st_q    <= st_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      tcnt_q  <= tcnt_d;
      to_q    <= to_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule
